// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and the LFSR step function for the lfsr_arbiter slice.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hFFFF;

  typedef enum logic {
    WARM,
    RUN
  } lfsr_state_e;

  // Fibonacci step for x^16+x^14+x^13+x^11+1; taps are bits 15,13,12,10.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 16-bit Fibonacci LFSR state register with load (zero seed replaced) and step controls.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      // An all-zero state would lock the LFSR forever.
      lfsr_d = (seed_i == '0) ? LFSR_SEED_DEFAULT : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter handing out one LFSR word per grant after a warm-up run.
// Define LFSR_ARB_STATS_EN to build the saturating per-requester grant counters.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WARM_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_we,
  input  logic [LFSR_W-1:0]      seed_data,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        gnt,
  output logic [LFSR_W-1:0]      rnd_data,
  output logic                   ready,
  output logic [NREQ*LFSR_W-1:0] grant_cnt
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WarmLast = 8'(WARM_CYCLES);

  lfsr_state_e       state_q, state_d;
  logic [7:0]        warm_q, warm_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [LFSR_W-1:0] rnd_q, rnd_d;
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_step, lfsr_load;
  logic              arb_en;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  int unsigned       scan_idx;

  lfsr_core u_core (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (seed_data),
    .state_o (lfsr_state)
  );

  // First set request searching upward from ptr+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NREQ;
      if (!win_found && req[scan_idx[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PtrW-1:0];
      end
    end
  end

  assign arb_en = (state_q == RUN) && !seed_we && (gnt_q == '0) && win_found;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    if (seed_we) begin
      lfsr_load = 1'b1;
      warm_d    = '0;
      state_d   = WARM;
    end else begin
      unique case (state_q)
        WARM: begin
          lfsr_step = 1'b1;
          warm_d    = warm_q + 8'd1;
          if (warm_d == WarmLast) state_d = RUN;
        end
        RUN: lfsr_step = arb_en;
        default: state_d = WARM;
      endcase
    end
  end

  always_comb begin
    gnt_d = '0;
    rnd_d = rnd_q;
    ptr_d = ptr_q;
    if (arb_en) begin
      gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      rnd_d = lfsr_state;
      ptr_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WARM;
      warm_q  <= '0;
      ptr_q   <= PtrW'(NREQ - 1);
      gnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign gnt      = gnt_q;
  assign rnd_data = rnd_q;
  assign ready    = (state_q == RUN);

`ifdef LFSR_ARB_STATS_EN
  logic [NREQ-1:0][LFSR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (seed_we) begin
        cnt_d[i] = '0;
      end else if (gnt_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + LFSR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: warm-up, round robin, seed reload and mid-stream reset.
module tb_lfsr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_we;
  logic [15:0] seed_data;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] rnd_data;
  logic        ready;
  logic [63:0] grant_cnt;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_arbiter #(
    .NREQ        (4),
    .WARM_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_we   (seed_we),
    .seed_data (seed_data),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .ready     (ready),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] model_run(input logic [15:0] s, input int n);
    logic [15:0] v = s;
    for (int i = 0; i < n; i++) v = model_step(v);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts sampled cycles with ready low, bounded; notes any grant seen meanwhile.
  task automatic wait_ready(output int n, output logic saw);
    n   = 0;
    saw = 1'b0;
    while (!ready && n < 40) begin
      if (gnt != 4'b0000) saw = 1'b1;
      n++;
      tick();
    end
  endtask

  logic [15:0] m0, m, last;
  logic [3:0]  rr_exp [9];
  logic [3:0]  one_exp [4];
  logic        saw;
  int          n;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    one_exp = '{4'b0000, 4'b0100, 4'b0000, 4'b0100};
    rst = 1'b0; seed_we = 1'b0; seed_data = 16'h0000; req = 4'b0000;
    tick(); tick();
    check("rst_gnt",   64'(gnt), 64'h0);
    check("rst_rnd",   64'(rnd_data), 64'h0);
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_cnt",   grant_cnt, 64'h0);
    check("rst_lfsr",  64'(dut.lfsr_state), 64'hFFFF);

    // Warm-up after reset release
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (gnt != 4'b0000) saw = 1'b1;
      if (i == 15) check("warm_ready_lo", 64'(ready), 64'h0);
    end
    check("warm_ready_hi", 64'(ready), 64'h1);
    check("warm_no_gnt", 64'(saw), 64'h0);
    m0 = model_run(16'hFFFF, 16);
    check("warm_lfsr", 64'(dut.lfsr_state), 64'(m0));

    // Round robin with all requesters active
    req  = 4'b1111;
    m    = m0;
    last = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_gnt", 64'(gnt), 64'(rr_exp[i]));
      if (rr_exp[i] != 4'b0000) begin
        check("rr_rnd", 64'(rnd_data), 64'(m));
        last = m;
        m    = model_step(m);
      end else begin
        check("rr_hold", 64'(rnd_data), 64'(last));
      end
    end
    req = 4'b0000;
    tick();
    check("rr_lfsr", 64'(dut.lfsr_state), 64'(m));
`ifdef LFSR_ARB_STATS_EN
    check("rr_cnt", grant_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
`else
    check("rr_cnt", grant_cnt, 64'h0);
`endif

    // Zero seed reload with requests pending
    seed_we = 1'b1; seed_data = 16'h0000; req = 4'b1111;
    tick();
    seed_we = 1'b0;
    check("seed0_lfsr",  64'(dut.lfsr_state), 64'hFFFF);
    check("seed0_ready", 64'(ready), 64'h0);
    check("seed0_nognt", 64'(gnt), 64'h0);
    check("seed0_cnt",   grant_cnt, 64'h0);
    wait_ready(n, saw);
    check("seed0_warm_len", 64'(n), 64'd16);
    check("seed0_warm_gnt", 64'(saw), 64'h0);
    tick();
    check("seed0_gnt", 64'(gnt), 64'(4'b0010));
    check("seed0_rnd", 64'(rnd_data), 64'(m0));
    req = 4'b0000;
    tick();

    // Seed load colliding with a request
    seed_we = 1'b1; seed_data = 16'h1234; req = 4'b0010;
    tick();
    seed_we = 1'b0;
    check("seed1_nognt", 64'(gnt), 64'h0);
    check("seed1_ready", 64'(ready), 64'h0);
    check("seed1_lfsr",  64'(dut.lfsr_state), 64'h1234);
    wait_ready(n, saw);
    check("seed1_warm_len", 64'(n), 64'd16);
    check("seed1_warm_gnt", 64'(saw), 64'h0);
    tick();
    m = model_run(16'h1234, 16);
    check("seed1_gnt", 64'(gnt), 64'(4'b0010));
    check("seed1_rnd", 64'(rnd_data), 64'(m));
    m = model_step(m);

    // Single requester held, then reset while a grant is out
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("one_gnt", 64'(gnt), 64'(one_exp[i]));
      if (one_exp[i] != 4'b0000) begin
        check("one_rnd", 64'(rnd_data), 64'(m));
        m = model_step(m);
      end
    end
    rst = 1'b0;
    #1;
    check("mid_rst_gnt",   64'(gnt), 64'h0);
    check("mid_rst_rnd",   64'(rnd_data), 64'h0);
    check("mid_rst_ready", 64'(ready), 64'h0);
    check("mid_rst_cnt",   grant_cnt, 64'h0);
    check("mid_rst_lfsr",  64'(dut.lfsr_state), 64'hFFFF);

    // Pointer reset: requester 0 beats requester 3
    rst = 1'b1; req = 4'b1001;
    wait_ready(n, saw);
    check("rel_warm_len", 64'(n), 64'd16);
    check("rel_warm_gnt", 64'(saw), 64'h0);
    tick();
    check("rel_gnt", 64'(gnt), 64'(4'b0001));
    check("rel_rnd", 64'(rnd_data), 64'(m0));
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
